// File: rtl/alu_seq.sv
// Button-driven sequential ALU: latches operand A, operand B and an opcode one
// enter strobe at a time, executes (iterative shift-add for MUL), then shows the result.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               hz100,
    input  logic               reset,
    input  logic               enter,
    input  logic               clear,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   a_q,
    output logic [WIDTH-1:0]   b_q,
    output logic [2:0]         op_q,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               busy,
    output logic               valid,
    output logic [2:0]         phase,
    output logic [15:0]        disp_val,
    output logic [3:0]         disp_en
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL1 = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_d, b_d;
    logic [2:0]        op_d;
    logic [PW-1:0]     result_q, result_d;
    logic              carry_q, carry_d, zero_q, zero_d;
    logic [PW-1:0]     acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [WIDTH:0]    add_w, sub_w;
    logic [WIDTH-1:0]  alu_r;
    logic              alu_c;
    logic [PW-1:0]     acc_next;

    // Single-cycle datapath for every opcode except MUL
    always_comb begin
        add_w = {1'b0, a_q} + {1'b0, b_q};
        sub_w = {1'b0, a_q} - {1'b0, b_q};
        alu_r = '0;
        alu_c = 1'b0;
        case (op_q)
            OP_ADD:  begin alu_r = add_w[WIDTH-1:0]; alu_c = add_w[WIDTH]; end
            OP_SUB:  begin alu_r = sub_w[WIDTH-1:0]; alu_c = sub_w[WIDTH]; end
            OP_AND:  alu_r = a_q & b_q;
            OP_OR:   alu_r = a_q | b_q;
            OP_XOR:  alu_r = a_q ^ b_q;
            OP_SHL1: begin alu_r = a_q << 1; alu_c = a_q[WIDTH-1]; end
            OP_PASS: alu_r = a_q;
            default: alu_r = '0;
        endcase
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state and register updates; clear overrides everything else
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (clear) begin
            state_d  = LOAD_A;
            a_d      = '0;
            b_d      = '0;
            op_d     = '0;
            result_d = '0;
            carry_d  = 1'b0;
            zero_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: if (enter) begin
                    a_d     = din;
                    state_d = LOAD_B;
                end
                LOAD_B: if (enter) begin
                    b_d     = din;
                    state_d = LOAD_OP;
                end
                LOAD_OP: if (enter) begin
                    op_d     = din[2:0];
                    acc_d    = '0;
                    mcand_d  = PW'(a_q);
                    mplier_d = b_q;
                    cnt_d    = '0;
                    state_d  = EXEC;
                end
                EXEC: begin
                    if (op_q == OP_MUL) begin
                        // Product is only exposed once the last partial sum lands
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            result_d = acc_next;
                            carry_d  = 1'b0;
                            zero_d   = (acc_next == '0);
                            state_d  = DONE;
                        end else begin
                            acc_d    = acc_next;
                            mcand_d  = mcand_q << 1;
                            mplier_d = mplier_q >> 1;
                            cnt_d    = cnt_q + CW'(1);
                        end
                    end else begin
                        result_d = PW'(alu_r);
                        carry_d  = alu_c;
                        zero_d   = (alu_r == '0);
                        state_d  = DONE;
                    end
                end
                DONE: if (enter) state_d = LOAD_A;
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign busy   = (state_q == EXEC);
    assign valid  = (state_q == DONE);
    assign phase  = state_q;

    // Seven-segment feed follows the current state
    always_comb begin
        disp_val = '0;
        disp_en  = 4'b0000;
        case (state_q)
            LOAD_A:  begin disp_val = 16'(din);            disp_en = 4'b0011; end
            LOAD_B:  begin disp_val = 16'({a_q, din});     disp_en = 4'b1111; end
            LOAD_OP: begin disp_val = 16'(din[2:0]);       disp_en = 4'b0001; end
            DONE:    begin disp_val = 16'(result_q);       disp_en = 4'b1111; end
            default: begin disp_val = '0;                  disp_en = 4'b0000; end
        endcase
    end

endmodule
